// File: rtl/calc_op_sequencer_if.sv
// Bus bundle for calc_op_sequencer: operation channel, result channel and
// divider-control link. The sequencer connects through the slave modport;
// the master modport is the environment side (issuer, consumer, divider).
interface calc_op_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic        flag;
    logic        div_start;
    logic        div_done;
    logic [7:0]  div_dividend;
    logic [7:0]  div_divisor;
    logic [7:0]  div_quot;
    logic [7:0]  div_rem;

    modport slave (
        input  op_valid, op_code, op_a, op_b, res_ready, div_done, div_quot, div_rem,
        output op_ready, res_valid, result, flag, div_start, div_dividend, div_divisor
    );

    modport master (
        output op_valid, op_code, op_a, op_b, res_ready, div_done, div_quot, div_rem,
        input  op_ready, res_valid, result, flag, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: front-end sequencer of the 8-bit four-function calculator.
// Add/sub in one cycle, 8-step shift-add multiply, divides dispatched to the
// external divider control (start pulse, then DONE 1->0->1 tracking).
// Optional macro CALC_DIV_TIMEOUT_EN: abort a divide after DIV_TIMEOUT clocks
// in DIV_ARM/DIV_WAIT with Result=16'hFFFF, Flag=1.
module calc_op_sequencer #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    calc_op_sequencer_if.slave    if_bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALU,
        ST_MUL,
        ST_DIV_SYNC,
        ST_DIV_GO,
        ST_DIV_ARM,
        ST_DIV_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_op_ready;
    logic [1:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_result;
    logic        r_flag;
    logic [7:0]  r_div_dividend;
    logic [7:0]  r_div_divisor;

    logic        r_mul_load;
    logic [2:0]  r_mul_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;

    logic        w_accept;
    logic        w_timeout;
    logic [8:0]  w_sum;
    logic [8:0]  w_diff;
    logic [15:0] w_acc_next;

    assign w_accept   = if_bus.op_valid && r_op_ready;
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef CALC_DIV_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    // Divide watchdog: cleared when the start pulse goes out, counts while waiting on the divider
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_DIV_GO) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_DIV_ARM || r_state == ST_DIV_WAIT) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ST_DIV_ARM || r_state == ST_DIV_WAIT) &&
                       (r_to_cnt == 8'(DIV_TIMEOUT - 1));
`else
    logic w_unused_div_timeout;
    assign w_unused_div_timeout = (DIV_TIMEOUT != 0);
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (if_bus.op_code)
                        2'b00, 2'b01: w_next = ST_ALU;
                        2'b10:        w_next = ST_MUL;
                        default: begin
                            // divide-by-zero result is formed in ALU so it appears one edge after accept
                            if (if_bus.op_b == 8'h00) begin
                                w_next = ST_ALU;
                            end else if (if_bus.div_done) begin
                                w_next = ST_DIV_GO;
                            end else begin
                                w_next = ST_DIV_SYNC;
                            end
                        end
                    endcase
                end
            end
            ST_ALU:      w_next = ST_RESP;
            ST_MUL: begin
                if (!r_mul_load && r_mul_cnt == 3'd7) begin
                    w_next = ST_RESP;
                end
            end
            ST_DIV_SYNC: begin
                if (if_bus.div_done) begin
                    w_next = ST_DIV_GO;
                end
            end
            ST_DIV_GO:   w_next = ST_DIV_ARM;
            ST_DIV_ARM: begin
                if (w_timeout) begin
                    w_next = ST_RESP;
                end else if (!if_bus.div_done) begin
                    w_next = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (if_bus.div_done || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (if_bus.res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default:     w_next = ST_IDLE;
        endcase
    end

    // OpReady registered so it stays low through the reset cycle and rises one edge later
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_ready <= 1'b0;
        end else begin
            r_op_ready <= (w_next == ST_IDLE);
        end
    end

    // Operand capture, ALU, shift-add multiplier and divide result capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_flag         <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_mul_load     <= 1'b0;
            r_mul_cnt      <= '0;
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= if_bus.op_code;
                r_a        <= if_bus.op_a;
                r_b        <= if_bus.op_b;
                r_mul_load <= 1'b1;
                r_mul_cnt  <= '0;
                if (if_bus.op_code == 2'b11 && if_bus.op_b != 8'h00) begin
                    r_div_dividend <= if_bus.op_a;
                    r_div_divisor  <= if_bus.op_b;
                end
            end
            case (r_state)
                ST_ALU: begin
                    case (r_op)
                        2'b00: begin
                            r_result <= {7'b0, w_sum};
                            r_flag   <= w_sum[8];
                        end
                        2'b01: begin
                            r_result <= {8'h00, w_diff[7:0]};
                            r_flag   <= w_diff[8];
                        end
                        default: begin
                            r_result <= 16'hFFFF;
                            r_flag   <= 1'b1;
                        end
                    endcase
                end
                ST_MUL: begin
                    // first MUL cycle loads the shifter, then iterations 0..7
                    if (r_mul_load) begin
                        r_acc      <= '0;
                        r_mcand    <= {8'h00, r_a};
                        r_mplier   <= r_b;
                        r_mul_load <= 1'b0;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_mcand   <= {r_mcand[14:0], 1'b0};
                        r_mplier  <= {1'b0, r_mplier[7:1]};
                        r_mul_cnt <= r_mul_cnt + 3'd1;
                        if (r_mul_cnt == 3'd7) begin
                            r_result <= w_acc_next;
                            r_flag   <= |w_acc_next[15:8];
                        end
                    end
                end
                ST_DIV_ARM: begin
                    if (w_timeout) begin
                        r_result <= 16'hFFFF;
                        r_flag   <= 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    if (if_bus.div_done) begin
                        r_result <= {if_bus.div_rem, if_bus.div_quot};
                        r_flag   <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= 16'hFFFF;
                        r_flag   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_bus.op_ready     = r_op_ready;
    assign if_bus.res_valid    = (r_state == ST_RESP);
    assign if_bus.result       = r_result;
    assign if_bus.flag         = r_flag;
    assign if_bus.div_start    = (r_state == ST_DIV_GO);
    assign if_bus.div_dividend = r_div_dividend;
    assign if_bus.div_divisor  = r_div_divisor;

endmodule
